// File: rtl/seq_reg_update_arbiter_pkg.sv
// Shared types and width helpers for the round-robin register-update arbiter.
package seq_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MAX_BURST = 4;

    // Index width never collapses to zero bits, even for a single entry.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int max_cnt);
        return $clog2(max_cnt + 1);
    endfunction

endpackage

// File: rtl/seq_reg_update_arbiter_if.sv
// Requester-side bus of the shared register arbiter: requests, data, grants and q.
interface seq_reg_update_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_i;
    logic [NUM_REQ-1:0]        lock_i;
    logic [NUM_REQ-1:0]        clr_i;
    logic [NUM_REQ*DATA_W-1:0] data_i;
    logic [NUM_REQ-1:0]        gnt_o;
    logic [DATA_W-1:0]         q_o;
    logic                      q_valid_o;
    logic                      busy_o;

    modport master (
        output req_i, lock_i, clr_i, data_i,
        input  gnt_o, q_o, q_valid_o, busy_o
    );

    modport slave (
        input  req_i, lock_i, clr_i, data_i,
        output gnt_o, q_o, q_valid_o, busy_o
    );
endinterface

// File: rtl/seq_reg_update_arbiter_picker.sv
// Combinational round-robin pick: first asserted request scanning from ptr upward, wrapping.
module seq_rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] winner,
    output logic          found
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             sum;

    // Rotating the doubled vector puts the request at ptr in bit 0.
    assign dbl = {req, req};
    assign rot = N'(dbl >> ptr);

    always_comb begin
        found = 1'b0;
        sum   = 0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = int'(ptr) + k;
            end
        end
        if (sum >= N) begin
            sum = sum - N;
        end
        winner = IW'(sum);
    end

endmodule

// File: rtl/seq_reg_update_arbiter.sv
// Shares one register q among NUM_REQ requesters, round-robin with bounded lock bursts.
//
// state | meaning
// IDLE  | no owner; first requester from rr_ptr is granted on the next edge
// OWN   | owner holds the grant; its request writes q, lock may extend the burst
module seq_reg_update_arbiter
    import seq_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input logic                     clk,
    input logic                     rst_n,
    seq_reg_update_arbiter_if.slave bus
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int CW = cnt_w(MAX_BURST);

    arb_state_e        state;
    logic [IW-1:0]     owner;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     next_ptr;
    logic [CW-1:0]     burst_cnt;
    logic [DATA_W-1:0] q;
    logic              q_valid;

    logic [IW-1:0]     idle_win;
    logic              idle_found;
    logic [IW-1:0]     rel_win;
    logic              rel_found;

    logic [DATA_W-1:0] data_arr [NUM_REQ];
    logic [NUM_REQ-1:0] gnt;
    logic              own_req;
    logic              hold;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data_arr[g] = bus.data_i[g*DATA_W +: DATA_W];
    end

    assign next_ptr = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);
    assign own_req  = bus.req_i[owner];
    assign hold     = own_req && bus.lock_i[owner] && (burst_cnt < CW'(MAX_BURST));

    seq_rr_picker #(.N(NUM_REQ), .IW(IW)) u_idle_pick (
        .req    (bus.req_i),
        .ptr    (rr_ptr),
        .winner (idle_win),
        .found  (idle_found)
    );

    // Release pick starts just past the owner so it re-wins only when alone.
    seq_rr_picker #(.N(NUM_REQ), .IW(IW)) u_rel_pick (
        .req    (bus.req_i),
        .ptr    (next_ptr),
        .winner (rel_win),
        .found  (rel_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            q         <= '0;
            q_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    q_valid <= 1'b0;
                    if (idle_found) begin
                        owner     <= idle_win;
                        burst_cnt <= CW'(1);
                        state     <= OWN;
                    end
                end
                OWN: begin
                    if (own_req) begin
                        q       <= bus.clr_i[owner] ? '0 : data_arr[owner];
                        q_valid <= 1'b1;
                    end else begin
                        q_valid <= 1'b0;
                    end
                    if (hold) begin
                        burst_cnt <= burst_cnt + CW'(1);
                    end else begin
                        rr_ptr <= next_ptr;
                        if (rel_found) begin
                            owner     <= rel_win;
                            burst_cnt <= CW'(1);
                        end else begin
                            burst_cnt <= '0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    q_valid <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        gnt = '0;
        if (state == OWN) begin
            gnt[owner] = 1'b1;
        end
    end

    assign bus.gnt_o     = gnt;
    assign bus.q_o       = q;
    assign bus.q_valid_o = q_valid;
    assign bus.busy_o    = (state == OWN);

endmodule

// File: tb/tb_seq_reg_update_arbiter.sv
// Directed bench for seq_reg_update_arbiter: reset, round-robin, burst lock, clear, drop.
module tb_seq_reg_update_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    seq_reg_update_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    seq_reg_update_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_data(input int idx, input logic [DATA_W-1:0] val);
        bus.data_i[idx*DATA_W +: DATA_W] = val;
    endtask

    task automatic check_out(input string tag, input logic [3:0] gnt, input logic [7:0] q,
                             input logic vld, input logic busy);
        check({tag, ".gnt"},   32'(bus.gnt_o),     32'(gnt));
        check({tag, ".q"},     32'(bus.q_o),       32'(q));
        check({tag, ".valid"}, 32'(bus.q_valid_o), 32'(vld));
        check({tag, ".busy"},  32'(bus.busy_o),    32'(busy));
    endtask

    logic [3:0] rr_gnt [5];
    logic [7:0] rr_q   [5];

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        rst_n       = 1'b0;
        bus.req_i   = '0;
        bus.lock_i  = '0;
        bus.clr_i   = '0;
        bus.data_i  = '0;
        rr_gnt      = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_q        = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13};

        step(); step();
        check_out("reset", 4'b0000, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Load A5 through requester 0, then pull reset mid-ownership.
        bus.req_i = 4'b0001;
        set_data(0, 8'hA5);
        step();
        check("load.gnt", 32'(bus.gnt_o), 32'h1);
        step();
        check_out("load", 4'b0001, 8'hA5, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 4'b0000, 8'h00, 1'b0, 1'b0);
        bus.req_i = '0;
        step();
        rst_n = 1'b1;
        step();
        check_out("post_rst", 4'b0000, 8'h00, 1'b0, 1'b0);

        // Round-robin with all four requesting, no lock.
        for (int i = 0; i < NUM_REQ; i++) set_data(i, 8'(8'h10 + i));
        bus.req_i = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("rr%0d.gnt", c), 32'(bus.gnt_o), 32'(rr_gnt[c]));
            if (c > 0) begin
                check($sformatf("rr%0d.q", c), 32'(bus.q_o), 32'(rr_q[c]));
                check($sformatf("rr%0d.valid", c), 32'(bus.q_valid_o), 32'h1);
            end
        end
        bus.req_i = '0;
        step();
        check_out("rr_end", 4'b0000, 8'h13, 1'b0, 1'b0);

        // Single request from requester 2 (pointer now 1).
        bus.req_i = 4'b0100;
        set_data(2, 8'h3C);
        step();
        check_out("single.c1", 4'b0100, 8'h13, 1'b0, 1'b1);
        step();
        check_out("single.c2", 4'b0100, 8'h3C, 1'b1, 1'b1);
        bus.req_i = '0;
        step();
        check_out("single.end", 4'b0000, 8'h3C, 1'b0, 1'b0);

        // Burst: requester 0 locks, requester 1 waits; lock refused after 4 cycles.
        bus.req_i  = 4'b0011;
        bus.lock_i = 4'b0001;
        set_data(0, 8'h55);
        set_data(1, 8'h66);
        for (int c = 1; c <= MAX_BURST; c++) begin
            step();
            check($sformatf("burst%0d.gnt", c), 32'(bus.gnt_o), 32'h1);
        end
        step();
        check_out("burst.handoff", 4'b0010, 8'h55, 1'b1, 1'b1);
        bus.req_i  = 4'b0010;
        bus.lock_i = '0;
        step();
        check_out("burst.w1", 4'b0010, 8'h66, 1'b1, 1'b1);
        bus.req_i = '0;
        step();
        check_out("burst.end", 4'b0000, 8'h66, 1'b0, 1'b0);

        // Clear beats data for owner 3; pointer wraps to 0 afterwards.
        bus.req_i = 4'b1000;
        bus.clr_i = 4'b1000;
        set_data(3, 8'hFF);
        step();
        check("clr.gnt", 32'(bus.gnt_o), 32'h8);
        step();
        check_out("clr.q", 4'b1000, 8'h00, 1'b1, 1'b1);
        bus.clr_i = '0;
        bus.req_i = 4'b1001;
        set_data(0, 8'h5A);
        step();
        check_out("wrap", 4'b0001, 8'hFF, 1'b1, 1'b1);
        bus.req_i = '0;
        step();
        check_out("wrap.end", 4'b0000, 8'hFF, 1'b0, 1'b0);

        // Lock without request is ignored; owner 1 then drops mid-grant.
        bus.lock_i = 4'b0010;
        step();
        check_out("lock_only", 4'b0000, 8'hFF, 1'b0, 1'b0);
        bus.lock_i = '0;
        bus.req_i  = 4'b0010;
        set_data(1, 8'h77);
        set_data(2, 8'h88);
        step();
        check("drop.gnt1", 32'(bus.gnt_o), 32'h2);
        bus.req_i = 4'b0100;
        step();
        check_out("drop.move", 4'b0100, 8'hFF, 1'b0, 1'b1);
        bus.req_i = '0;
        step();
        check_out("drop.idle", 4'b0000, 8'hFF, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
